// File: rtl/psx_host_poller.sv
// rtl/psx_host_poller.sv - host-side PSX/PS2 controller poll engine
//
// Runs one poll transaction (01 42 00 00 ..) per accepted start strobe and
// stores the controller's input bytes in a 32x8 buffer.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   PSX_sel/clk/cmd     link outputs (select active low, clock idles high)
//   PSX_dat, PSX_ack    link inputs, each double-flop synchronised
//   start               1-cycle poll request, ignored while busy or with done
//   busy, done          transaction in progress / 1-cycle end pulse
//   err_timeout         last transaction aborted waiting for ack
//   err_header          last transaction aborted on a byte-2 reply != 5A
//   mode                high nibble of the byte-1 reply
//   reply_len           input bytes stored by the last transaction
//   read_addr/read_data buffer read port, 1-cycle registered latency
module psx_host_poller #(
    parameter int CLOCK_MHZ      = 25,
    parameter int BIT_KHZ        = 250,
    parameter int ACK_TIMEOUT_US = 100
) (
    input  logic       clk,
    input  logic       reset,
    output logic       PSX_sel,
    output logic       PSX_clk,
    output logic       PSX_cmd,
    input  logic       PSX_dat,
    input  logic       PSX_ack,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       err_timeout,
    output logic       err_header,
    output logic [3:0] mode,
    output logic [5:0] reply_len,
    input  logic [4:0] read_addr,
    output logic [7:0] read_data
);

    localparam int HALF    = CLOCK_MHZ * 1000 / (2 * BIT_KHZ);
    localparam int ACK_TO  = ACK_TIMEOUT_US * CLOCK_MHZ;
    localparam int CNT_MAX = (ACK_TO > 2 * HALF) ? ACK_TO : 2 * HALF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] SETUP_M1 = CNT_W'(2 * HALF - 1);
    localparam logic [CNT_W-1:0] TO_M1    = CNT_W'(ACK_TO - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL_SETUP,
        S_BIT_LOW,
        S_BIT_HIGH,
        S_ACK_WAIT,
        S_GAP,
        S_FINISH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [5:0]       byte_q, byte_d;
    logic [5:0]       last_q, last_d;
    logic [7:0]       rx_q, rx_d;
    logic             sel_q, sel_d;
    logic             sclk_q, sclk_d;
    logic             cmd_q, cmd_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_to_q, err_to_d;
    logic             err_hdr_q, err_hdr_d;
    logic [3:0]       mode_q, mode_d;
    logic [5:0]       len_q, len_d;
    logic [7:0]       read_data_q;
    logic             dat_s1_q, dat_s2_q;
    logic             ack_s1_q, ack_s2_q;
    logic             wr_en;
    logic [7:0]       cur_cmd;

    logic [7:0] mem [0:31];

    // Command byte sent in position idx of the poll sequence.
    function automatic logic [7:0] cmd_byte(input logic [5:0] idx);
        if (idx == 6'd0) begin
            return 8'h01;
        end else if (idx == 6'd1) begin
            return 8'h42;
        end
        return 8'h00;
    endfunction

    always_comb cur_cmd = cmd_byte(byte_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            byte_q      <= 6'd0;
            last_q      <= 6'd34;
            rx_q        <= 8'h00;
            sel_q       <= 1'b1;
            sclk_q      <= 1'b1;
            cmd_q       <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_to_q    <= 1'b0;
            err_hdr_q   <= 1'b0;
            mode_q      <= 4'd0;
            len_q       <= 6'd0;
            read_data_q <= 8'h00;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            ack_s1_q    <= 1'b1;
            ack_s2_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            rx_q        <= rx_d;
            sel_q       <= sel_d;
            sclk_q      <= sclk_d;
            cmd_q       <= cmd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_to_q    <= err_to_d;
            err_hdr_q   <= err_hdr_d;
            mode_q      <= mode_d;
            len_q       <= len_d;
            read_data_q <= mem[read_addr];
            dat_s1_q    <= PSX_dat;
            dat_s2_q    <= dat_s1_q;
            ack_s1_q    <= PSX_ack;
            ack_s2_q    <= ack_s1_q;
        end
    end

    // Bytes are stored in arrival order, so the running count is the address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len_q[4:0]] <= rx_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        last_d    = last_q;
        rx_d      = rx_q;
        sel_d     = sel_q;
        sclk_d    = sclk_q;
        cmd_d     = cmd_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_to_d  = err_to_q;
        err_hdr_d = err_hdr_q;
        mode_d    = mode_q;
        len_d     = len_q;
        wr_en     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A start coinciding with the done pulse is dropped.
                if (start && !done_q) begin
                    busy_d    = 1'b1;
                    sel_d     = 1'b0;
                    err_to_d  = 1'b0;
                    err_hdr_d = 1'b0;
                    len_d     = 6'd0;
                    byte_d    = 6'd0;
                    bit_d     = 3'd0;
                    cnt_d     = '0;
                    state_d   = S_SEL_SETUP;
                end
            end

            S_SEL_SETUP: begin
                if (cnt_q == SETUP_M1) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    cmd_d   = cur_cmd[0];
                    state_d = S_BIT_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_BIT_LOW: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b1;
                    rx_d    = {dat_s2_q, rx_q[7:1]};
                    state_d = S_BIT_HIGH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_BIT_HIGH: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    if (bit_q != 3'd7) begin
                        bit_d   = bit_q + 3'd1;
                        sclk_d  = 1'b0;
                        cmd_d   = cur_cmd[bit_q + 3'd1];
                        state_d = S_BIT_LOW;
                    end else begin
                        // Whole byte received: rx_q holds it, LSB first.
                        bit_d   = 3'd0;
                        cmd_d   = 1'b1;
                        byte_d  = byte_q + 6'd1;
                        state_d = S_ACK_WAIT;
                        if (byte_q == 6'd1) begin
                            mode_d = rx_q[7:4];
                            // Final byte index is N+2, N = 2n with n=0 meaning 32.
                            last_d = (rx_q[3:0] == 4'd0) ? 6'd34
                                   : ({1'b0, rx_q[3:0], 1'b0} + 6'd2);
                        end else if (byte_q == 6'd2) begin
                            if (rx_q != 8'h5A) begin
                                err_hdr_d = 1'b1;
                                state_d   = S_FINISH;
                            end
                        end else if (byte_q >= 6'd3) begin
                            wr_en = 1'b1;
                            len_d = len_q + 6'd1;
                            if (byte_q == last_q) begin
                                state_d = S_FINISH;
                            end
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_ACK_WAIT: begin
                if (!ack_s2_q) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (cnt_q == TO_M1) begin
                    cnt_d    = '0;
                    err_to_d = 1'b1;
                    state_d  = S_FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_GAP: begin
                // Counter restarts while ack is still low, so the HALF delay
                // is measured from ack release.
                if (!ack_s2_q) begin
                    cnt_d = '0;
                end else if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    sclk_d  = 1'b0;
                    cmd_d   = cur_cmd[0];
                    state_d = S_BIT_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_FINISH: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    sel_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign PSX_sel     = sel_q;
    assign PSX_clk     = sclk_q;
    assign PSX_cmd     = cmd_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_to_q;
    assign err_header  = err_hdr_q;
    assign mode        = mode_q;
    assign reply_len   = len_q;
    assign read_data   = read_data_q;

endmodule

// File: tb/tb_psx_host_poller.sv
// tb/tb_psx_host_poller.sv - directed self-checking bench for psx_host_poller
module tb_psx_host_poller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       PSX_sel, PSX_clk, PSX_cmd;
    logic       PSX_dat = 1'b1;
    logic       PSX_ack = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, err_timeout, err_header;
    logic [3:0] mode;
    logic [5:0] reply_len;
    logic [4:0] read_addr = 5'd0;
    logic [7:0] read_data;

    int n_checks = 0;
    int n_fail   = 0;

    psx_host_poller dut (
        .clk        (clk),
        .reset      (reset),
        .PSX_sel    (PSX_sel),
        .PSX_clk    (PSX_clk),
        .PSX_cmd    (PSX_cmd),
        .PSX_dat    (PSX_dat),
        .PSX_ack    (PSX_ack),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err_timeout(err_timeout),
        .err_header (err_header),
        .mode       (mode),
        .reply_len  (reply_len),
        .read_addr  (read_addr),
        .read_data  (read_data)
    );

    always #5 clk = ~clk;

    // Controller model: replies rep[] LSB first, acks every byte except its last.
    logic [7:0] rep [0:15];
    int         rep_len = 0;
    bit         ack_en = 1'b0;
    logic [7:0] cmd_log [0:39];
    logic [7:0] dev_sh = 8'h00;
    int         dev_byte = 0;
    int         dev_bit = 0;
    event       ack_ev;

    always @(negedge PSX_sel) begin
        dev_byte = 0;
        dev_bit  = 0;
    end

    always @(posedge PSX_sel) PSX_dat = 1'b1;

    always @(negedge PSX_clk) begin
        if (PSX_sel === 1'b0) begin
            if (dev_byte < rep_len) PSX_dat = rep[dev_byte][dev_bit];
            else PSX_dat = 1'b1;
        end
    end

    always @(posedge PSX_clk) begin
        if (PSX_sel === 1'b0) begin
            dev_sh[dev_bit] = PSX_cmd;
            dev_bit = dev_bit + 1;
            if (dev_bit == 8) begin
                if (dev_byte < 40) cmd_log[dev_byte] = dev_sh;
                dev_bit  = 0;
                dev_byte = dev_byte + 1;
                if (ack_en && dev_byte < rep_len) -> ack_ev;
            end
        end
    end

    always begin
        @(ack_ev);
        repeat (80) @(negedge clk);
        PSX_ack = 1'b0;
        repeat (10) @(negedge clk);
        PSX_ack = 1'b1;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic read_buf(input logic [4:0] a, output logic [7:0] d);
        @(negedge clk);
        read_addr = a;
        @(negedge clk);
        d = read_data;
    endtask

    task automatic load_digital();
        rep[0] = 8'hFF; rep[1] = 8'h41; rep[2] = 8'h5A; rep[3] = 8'h7F; rep[4] = 8'hFF;
        rep_len = 5;
        ack_en  = 1'b1;
    endtask

    task automatic test_reset();
        if ({PSX_sel, PSX_clk, PSX_cmd} !== 3'b111) begin
            n_fail++; $display("FAIL reset_link: got %b want 111", {PSX_sel, PSX_clk, PSX_cmd});
        end
        n_checks++;
        if ({busy, done, err_timeout, err_header} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err_timeout, err_header});
        end
        n_checks++;
        if (mode !== 4'd0 || reply_len !== 6'd0 || read_data !== 8'h00) begin
            n_fail++; $display("FAIL reset_regs: mode %h len %0d rd %h want 0 0 00", mode, reply_len, read_data);
        end
        n_checks++;
    endtask

    task automatic test_digital();
        bit ok;
        logic [7:0] d, e;
        load_digital();
        pulse_start();
        if (busy !== 1'b1) begin n_fail++; $display("FAIL dig_busy: got %b want 1", busy); end
        n_checks++;
        wait_done(20000, ok);
        if (!ok) begin n_fail++; $display("FAIL dig_done: got no done want done"); end
        n_checks++;
        if (PSX_sel !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL dig_release: sel %b busy %b want 1 0", PSX_sel, busy);
        end
        n_checks++;
        if (dev_byte !== 5) begin n_fail++; $display("FAIL dig_nbytes: got %0d want 5", dev_byte); end
        n_checks++;
        for (int i = 0; i < 5; i++) begin
            e = (i == 0) ? 8'h01 : (i == 1) ? 8'h42 : 8'h00;
            if (cmd_log[i] !== e) begin
                n_fail++; $display("FAIL dig_cmd%0d: got %h want %h", i, cmd_log[i], e);
            end
            n_checks++;
        end
        if (mode !== 4'h4 || reply_len !== 6'd2 || err_timeout !== 1'b0 || err_header !== 1'b0) begin
            n_fail++; $display("FAIL dig_status: mode %h len %0d to %b hdr %b want 4 2 0 0",
                               mode, reply_len, err_timeout, err_header);
        end
        n_checks++;
        @(negedge clk);
        if (done !== 1'b0) begin n_fail++; $display("FAIL dig_done_width: got %b want 0", done); end
        n_checks++;
        read_buf(5'd0, d);
        if (d !== 8'h7F) begin n_fail++; $display("FAIL dig_buf0: got %h want 7F", d); end
        n_checks++;
        read_buf(5'd1, d);
        if (d !== 8'hFF) begin n_fail++; $display("FAIL dig_buf1: got %h want FF", d); end
        n_checks++;
    endtask

    task automatic test_analog();
        bit ok;
        logic [7:0] d;
        logic [7:0] exp_buf [0:5];
        exp_buf[0] = 8'h7F; exp_buf[1] = 8'hFF; exp_buf[2] = 8'h80;
        exp_buf[3] = 8'h80; exp_buf[4] = 8'h10; exp_buf[5] = 8'hF0;
        rep[0] = 8'hFF; rep[1] = 8'h73; rep[2] = 8'h5A;
        for (int i = 0; i < 6; i++) rep[3 + i] = exp_buf[i];
        rep_len = 9;
        ack_en  = 1'b1;
        pulse_start();
        wait_done(30000, ok);
        if (!ok) begin n_fail++; $display("FAIL ana_done: got no done want done"); end
        n_checks++;
        if (dev_byte !== 9) begin n_fail++; $display("FAIL ana_nbytes: got %0d want 9", dev_byte); end
        n_checks++;
        if (mode !== 4'h7 || reply_len !== 6'd6) begin
            n_fail++; $display("FAIL ana_status: mode %h len %0d want 7 6", mode, reply_len);
        end
        n_checks++;
        for (int i = 0; i < 6; i++) begin
            read_buf(5'(i), d);
            if (d !== exp_buf[i]) begin
                n_fail++; $display("FAIL ana_buf%0d: got %h want %h", i, d, exp_buf[i]);
            end
            n_checks++;
        end
    endtask

    task automatic test_timing();
        int first_fall, low_start, high_start, first_high, n_low, bad_low, bad_cmd;
        logic prev_clk, prev_cmd;
        bit ok;
        load_digital();
        pulse_start();
        if (PSX_sel !== 1'b0) begin n_fail++; $display("FAIL tim_sel: got %b want 0", PSX_sel); end
        n_checks++;
        first_fall = -1; first_high = -1; high_start = -1; low_start = 0;
        n_low = 0; bad_low = 0; bad_cmd = 0; ok = 1'b0;
        prev_clk = PSX_clk; prev_cmd = PSX_cmd;
        for (int i = 1; i < 20000; i++) begin
            @(negedge clk);
            if (prev_clk === 1'b1 && PSX_clk === 1'b0) begin
                if (first_fall < 0) first_fall = i;
                if (high_start >= 0 && first_high < 0) first_high = i - high_start;
                low_start = i;
            end
            if (prev_clk === 1'b0 && PSX_clk === 1'b1) begin
                n_low++;
                if (i - low_start != 50) bad_low++;
                if (PSX_cmd !== prev_cmd) bad_cmd++;
                if (high_start < 0) high_start = i;
            end
            prev_clk = PSX_clk;
            prev_cmd = PSX_cmd;
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) begin n_fail++; $display("FAIL tim_done: got no done want done"); end
        n_checks++;
        if (first_fall != 100) begin n_fail++; $display("FAIL tim_sel_to_fall: got %0d want 100", first_fall); end
        n_checks++;
        if (first_high != 50) begin n_fail++; $display("FAIL tim_high: got %0d want 50", first_high); end
        n_checks++;
        if (n_low != 40 || bad_low != 0) begin
            n_fail++; $display("FAIL tim_low: pulses %0d wrong %0d want 40 0", n_low, bad_low);
        end
        n_checks++;
        if (bad_cmd != 0) begin n_fail++; $display("FAIL tim_cmd_stable: got %0d changes want 0", bad_cmd); end
        n_checks++;
    endtask

    task automatic test_timeout();
        int t_err, t_done;
        rep_len = 0;
        ack_en  = 1'b0;
        pulse_start();
        t_err = -1; t_done = -1;
        for (int i = 1; i < 6000; i++) begin
            @(negedge clk);
            if (err_timeout === 1'b1 && t_err < 0) t_err = i;
            if (done === 1'b1) begin
                t_done = i;
                if (PSX_sel !== 1'b1) begin n_fail++; $display("FAIL to_sel: got %b want 1", PSX_sel); end
                n_checks++;
                break;
            end
        end
        if (t_err != 3400) begin n_fail++; $display("FAIL to_err_time: got %0d want 3400", t_err); end
        n_checks++;
        if (t_done != 3450) begin n_fail++; $display("FAIL to_done_time: got %0d want 3450", t_done); end
        n_checks++;
        if (reply_len !== 6'd0 || err_header !== 1'b0 || dev_byte !== 1) begin
            n_fail++; $display("FAIL to_status: len %0d hdr %b bytes %0d want 0 0 1",
                               reply_len, err_header, dev_byte);
        end
        n_checks++;
    endtask

    task automatic test_header();
        bit ok;
        rep[0] = 8'hFF; rep[1] = 8'h41; rep[2] = 8'h00;
        rep_len = 3;
        ack_en  = 1'b1;
        pulse_start();
        wait_done(20000, ok);
        if (!ok) begin n_fail++; $display("FAIL hdr_done: got no done want done"); end
        n_checks++;
        if (err_header !== 1'b1 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL hdr_flags: hdr %b to %b want 1 0", err_header, err_timeout);
        end
        n_checks++;
        if (dev_byte !== 3 || reply_len !== 6'd0 || PSX_sel !== 1'b1) begin
            n_fail++; $display("FAIL hdr_frame: bytes %0d len %0d sel %b want 3 0 1",
                               dev_byte, reply_len, PSX_sel);
        end
        n_checks++;
    endtask

    task automatic test_back_to_back();
        bit ok, moved;
        load_digital();
        pulse_start();
        repeat (500) @(negedge clk);
        pulse_start();
        wait_done(20000, ok);
        if (!ok) begin n_fail++; $display("FAIL b2b_done: got no done want done"); end
        n_checks++;
        moved = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || PSX_sel !== 1'b1) moved = 1'b1;
        end
        if (moved) begin n_fail++; $display("FAIL b2b_busy_drop: got restart want idle"); end
        n_checks++;
        pulse_start();
        wait_done(20000, ok);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (!ok) begin n_fail++; $display("FAIL b2b_done2: got no done want done"); end
        n_checks++;
        moved = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy !== 1'b0 || PSX_sel !== 1'b1) moved = 1'b1;
            @(negedge clk);
        end
        if (moved) begin n_fail++; $display("FAIL b2b_done_drop: got restart want idle"); end
        n_checks++;
    endtask

    task automatic test_reset_mid();
        bit ok, hit;
        logic [7:0] d;
        rep[0] = 8'hFF; rep[1] = 8'h73; rep[2] = 8'h5A;
        for (int i = 3; i < 9; i++) rep[i] = 8'h11;
        rep_len = 9;
        ack_en  = 1'b1;
        pulse_start();
        hit = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (dev_byte == 3 && dev_bit == 4 && PSX_clk === 1'b0) begin hit = 1'b1; break; end
        end
        if (!hit) begin n_fail++; $display("FAIL rm_reach: got no byte 3 want byte 3"); end
        n_checks++;
        #1 reset = 1'b1;
        #1;
        if ({PSX_sel, PSX_clk, PSX_cmd} !== 3'b111 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rm_async: link %b busy %b want 111 0", {PSX_sel, PSX_clk, PSX_cmd}, busy);
        end
        n_checks++;
        if (mode !== 4'd0 || reply_len !== 6'd0) begin
            n_fail++; $display("FAIL rm_regs: mode %h len %0d want 0 0", mode, reply_len);
        end
        n_checks++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        load_digital();
        pulse_start();
        wait_done(20000, ok);
        if (!ok || reply_len !== 6'd2 || err_timeout !== 1'b0 || err_header !== 1'b0) begin
            n_fail++; $display("FAIL rm_repoll: done %b len %0d to %b hdr %b want 1 2 0 0",
                               ok, reply_len, err_timeout, err_header);
        end
        n_checks++;
        read_buf(5'd0, d);
        if (d !== 8'h7F) begin n_fail++; $display("FAIL rm_buf0: got %h want 7F", d); end
        n_checks++;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        test_digital();
        test_analog();
        test_timing();
        test_timeout();
        test_header();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
